spell_mem_banked: RTL and testbench

Parametrised internal memory for the SPELL core: byte-addressed code memory built from N 32x32-bit RAM32 banks, plus a flip-flop data memory.
- Code memory is filled with CODE_FILL after reset.
- Optional wait states per access.
- Out-of-range accesses are flagged.
- Sits between the SPELL execution unit and its memory port, behind the select/data_ready handshake.

---
 rtl/spell_mem_banked_pkg.sv | 21 ++
 rtl/spell_mem_banked_code_bank.sv | 77 +++++++
 rtl/spell_mem_banked.sv | 151 +++++++++++++++
 tb/tb_spell_mem_banked.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/spell_mem_banked_pkg.sv
// Shared constants and helpers for the SPELL banked memory slice.
package spell_mem_pkg;

    localparam int unsigned RAM32_WORDS = 32;
    localparam int unsigned RAM32_BYTES = 128;
    localparam logic [4:0]  INIT_LAST   = 5'd31;

    typedef enum logic {
        PH_INIT,
        PH_RUN
    } phase_e;

    // Ceiling log2, used for elaboration-time width calculations.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        for (r = 0; (32'd1 << r) < v; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/spell_mem_banked_code_bank.sv
// One RAM32 code bank: bank-select and byte-lane write-enable decode in front
// of a 32x32 synchronous RAM (macro or behavioural stand-in).
module spell_code_bank
    import spell_mem_pkg::*;
#(
    parameter int unsigned BANK_W  = 1,
    parameter int unsigned BANK_ID = 0
) (
    input  logic              clk,
    input  logic              init_i,
    input  logic [4:0]        init_addr_i,
    input  logic [7:0]        fill_i,
    input  logic              req_i,
    input  logic              wr_i,
    input  logic [BANK_W-1:0] bank_i,
    input  logic [4:0]        word_i,
    input  logic [1:0]        lane_i,
    input  logic [7:0]        wdata_i,
    output logic [31:0]       rdata_o
);

    logic        hit;
    logic        en;
    logic [3:0]  we;
    logic [4:0]  a;
    logic [31:0] di;

    assign hit = (bank_i == BANK_W'(BANK_ID));

    // Init fill overrides normal accesses; a write only touches its own lane.
    always_comb begin
        en = 1'b0;
        we = '0;
        a  = word_i;
        di = {4{wdata_i}};
        if (init_i) begin
            en = 1'b1;
            we = '1;
            a  = init_addr_i;
            di = {4{fill_i}};
        end else if (req_i && hit) begin
            en = 1'b1;
            if (wr_i) begin
                we[lane_i] = 1'b1;
            end
        end
    end

`ifdef SPELL_USE_RAM32_MACRO
    RAM32 u_ram (
        .CLK (clk),
        .EN0 (en),
        .WE0 (we),
        .A0  (a),
        .Di0 (di),
        .Do0 (rdata_o)
    );
`else
    logic [31:0] mem_q [RAM32_WORDS];
    logic [31:0] rdata_q;

    // Behavioural RAM32: per-byte write, registered read of the old contents.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem_q[a][8*i +: 8] <= di[8*i +: 8];
                end
            end
            rdata_q <= mem_q[a];
        end
    end

    assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/spell_mem_banked.sv
// SPELL internal memory: banked RAM32 code memory with init fill, flip-flop
// data memory, wait states, range check and select/data_ready handshake.
module spell_mem_banked
    import spell_mem_pkg::*;
#(
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned CODE_BANKS    = 2,
    parameter int unsigned DATA_MEM_SIZE = 32,
    parameter int unsigned WAIT_CYCLES   = 0,
    parameter logic [7:0]  CODE_FILL     = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              select,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data_in,
    input  logic              memory_type_data,
    input  logic              write,
    output logic [7:0]        data_out,
    output logic              data_ready,
    output logic              busy,
    output logic              error
);

    localparam int unsigned BANK_W     = ADDR_W - 7;
    localparam int unsigned NSLOT      = 1 << BANK_W;
    localparam int unsigned DATA_AW    = clog2(DATA_MEM_SIZE);
    localparam int unsigned CODE_LIMIT = CODE_BANKS * RAM32_BYTES;

    phase_e              phase_q;
    logic [4:0]          init_addr_q;
    logic [2:0]          cnt_q;
    logic                ready_q;
    logic                err_q;
    logic                rd_q;
    logic                type_q;
    logic [BANK_W-1:0]   bank_q;
    logic [1:0]          lane_q;
    logic [7:0]          dout_q;
    logic [7:0]          dmem_q [DATA_MEM_SIZE];

    logic [31:0]         addr_ext;
    logic                oor;
    logic                busy_w;
    logic                go;
    logic                code_req;
    logic                code_wr;
    logic [BANK_W-1:0]   bank_a;
    logic [DATA_AW-1:0]  didx;
    logic [31:0]         bank_rdata [NSLOT];
    logic [31:0]         sel_word;

    assign busy_w   = (phase_q == PH_INIT);
    assign addr_ext = {{(32-ADDR_W){1'b0}}, addr};
    assign oor      = memory_type_data ? (addr_ext >= DATA_MEM_SIZE)
                                       : (addr_ext >= CODE_LIMIT);
    assign bank_a   = addr[ADDR_W-1:7];
    assign didx     = addr[DATA_AW-1:0];

    // Execution is gated by rst_n so a reset landing on the execute cycle
    // cannot commit the combinationally-decoded RAM write.
    assign go       = rst_n && !busy_w && select && !ready_q && (cnt_q == 3'd0);
    assign code_req = rst_n && !busy_w && select && !memory_type_data;
    assign code_wr  = go && write && !memory_type_data && !oor;

    for (genvar b = 0; b < NSLOT; b++) begin : g_bank
        if (b < CODE_BANKS) begin : g_inst
            spell_code_bank #(
                .BANK_W  (BANK_W),
                .BANK_ID (b)
            ) u_bank (
                .clk         (clk),
                .init_i      (busy_w),
                .init_addr_i (init_addr_q),
                .fill_i      (CODE_FILL),
                .req_i       (code_req),
                .wr_i        (code_wr),
                .bank_i      (bank_a),
                .word_i      (addr[6:2]),
                .lane_i      (addr[1:0]),
                .wdata_i     (data_in),
                .rdata_o     (bank_rdata[b])
            );
        end else begin : g_empty
            assign bank_rdata[b] = '0;
        end
    end

    // Init sequencer, wait counter, handshake and data memory.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q     <= PH_INIT;
            init_addr_q <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            rd_q        <= 1'b0;
            type_q      <= 1'b0;
            bank_q      <= '0;
            lane_q      <= '0;
            dout_q      <= '0;
            for (int unsigned i = 0; i < DATA_MEM_SIZE; i++) begin
                dmem_q[i] <= '0;
            end
        end else begin
            if (phase_q == PH_INIT) begin
                init_addr_q <= init_addr_q + 5'd1;
                if (init_addr_q == INIT_LAST) begin
                    phase_q <= PH_RUN;
                end
            end
            if (busy_w || !select) begin
                ready_q <= 1'b0;
                err_q   <= 1'b0;
                cnt_q   <= 3'(WAIT_CYCLES);
            end else if (!ready_q) begin
                if (cnt_q != 3'd0) begin
                    cnt_q <= cnt_q - 3'd1;
                end else begin
                    ready_q <= 1'b1;
                    err_q   <= oor;
                    rd_q    <= !write;
                    type_q  <= memory_type_data;
                    bank_q  <= bank_a;
                    lane_q  <= addr[1:0];
                    if (memory_type_data) begin
                        dout_q <= oor ? 8'h00 : dmem_q[didx];
                        if (write && !oor) begin
                            dmem_q[didx] <= data_in;
                        end
                    end
                end
            end
        end
    end

    assign sel_word = bank_rdata[bank_q];

    // Output mux; anything but a completed in-range read shows 8'h00.
    always_comb begin
        data_out = 8'h00;
        if (ready_q && !err_q && rd_q) begin
            data_out = type_q ? dout_q : sel_word[8*lane_q +: 8];
        end
    end

    assign data_ready = ready_q;
    assign busy       = busy_w;
    assign error      = err_q;

endmodule

// File: tb/tb_spell_mem_banked.sv
// Directed bench for spell_mem_banked (ADDR_W=8, 2 banks, 32-byte data, 3 waits).
module tb_spell_mem_banked;

    logic       clk;
    logic       rst_n;
    logic       select;
    logic [7:0] addr;
    logic [7:0] data_in;
    logic       memory_type_data;
    logic       write;
    logic [7:0] data_out;
    logic       data_ready;
    logic       busy;
    logic       error;

    int n_checks = 0;
    int n_pass   = 0;

    spell_mem_banked #(
        .ADDR_W        (8),
        .CODE_BANKS    (2),
        .DATA_MEM_SIZE (32),
        .WAIT_CYCLES   (3),
        .CODE_FILL     (8'hFF)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .select           (select),
        .addr             (addr),
        .data_in          (data_in),
        .memory_type_data (memory_type_data),
        .write            (write),
        .data_out         (data_out),
        .data_ready       (data_ready),
        .busy             (busy),
        .error            (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Release reset at a negedge and count cycles with busy high (bounded).
    task automatic release_and_wait(output int n);
        rst_n = 1'b1;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One full handshake: request, wait for data_ready, drop select.
    task automatic access(input string tag, input logic mt, input logic wr,
                          input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] exp_data, input logic exp_err);
        int lat;
        @(negedge clk);
        memory_type_data = mt;
        write            = wr;
        addr             = a;
        data_in          = d;
        select           = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!data_ready && lat < 50);
        check({tag, "_lat"}, 32'(lat), 32'd4);
        if (!wr) check({tag, "_data"}, 32'(data_out), 32'(exp_data));
        check({tag, "_err"}, 32'(error), 32'(exp_err));
        @(negedge clk);
        select = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_rdy_fall"}, 32'(data_ready), 32'd0);
        check({tag, "_dout_gate"}, 32'(data_out), 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; select = 1'b0; addr = '0; data_in = '0;
        memory_type_data = 1'b0; write = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_ready", 32'(data_ready), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
        release_and_wait(n);
        check("init_cycles", 32'(n), 32'd32);

        // Fill visible at both ends of code space.
        access("code_rd00", 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b0);
        access("code_rdFF", 1'b0, 1'b0, 8'hFF, 8'h00, 8'hFF, 1'b0);

        // Single-lane code write.
        access("code_wr05", 1'b0, 1'b1, 8'h05, 8'h41, 8'h00, 1'b0);
        access("code_rd04", 1'b0, 1'b0, 8'h04, 8'h00, 8'hFF, 1'b0);
        access("code_rd05", 1'b0, 1'b0, 8'h05, 8'h00, 8'h41, 1'b0);
        access("code_rd06", 1'b0, 1'b0, 8'h06, 8'h00, 8'hFF, 1'b0);
        access("code_rd07", 1'b0, 1'b0, 8'h07, 8'h00, 8'hFF, 1'b0);
        access("code_rd85", 1'b0, 1'b0, 8'h85, 8'h00, 8'hFF, 1'b0);

        // Data memory and range check.
        access("data_rd03", 1'b1, 1'b0, 8'h03, 8'h00, 8'h00, 1'b0);
        access("data_wr1F", 1'b1, 1'b1, 8'h1F, 8'h5A, 8'h00, 1'b0);
        access("data_rd1F", 1'b1, 1'b0, 8'h1F, 8'h00, 8'h5A, 1'b0);
        access("data_wr20", 1'b1, 1'b1, 8'h20, 8'hC3, 8'h00, 1'b1);
        access("data_rd20", 1'b1, 1'b0, 8'h20, 8'h00, 8'h00, 1'b1);
        access("data_rd1Fb", 1'b1, 1'b0, 8'h1F, 8'h00, 8'h5A, 1'b0);
        access("data_rd00", 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

        // Request raised during init is held off until busy falls.
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        memory_type_data = 1'b0; write = 1'b0; addr = 8'h05; select = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (busy && data_ready) check("ready_while_busy", 32'(data_ready), 32'd0);
        end while (!data_ready && n < 100);
        check("held_lat", 32'(n), 32'd31);
        check("held_busy", 32'(busy), 32'd0);
        check("held_refill", 32'(data_out), 32'hFF);
        check("held_err", 32'(error), 32'd0);
        @(negedge clk);
        select = 1'b0;
        access("data_cleared", 1'b1, 1'b0, 8'h1F, 8'h00, 8'h00, 1'b0);

        // Reset during the wait phase of a code write.
        @(negedge clk);
        memory_type_data = 1'b0; write = 1'b1; addr = 8'h10; data_in = 8'h33; select = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; select = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        release_and_wait(n);
        check("rst_mid_code_init", 32'(n), 32'd32);

        // Reset landing on the execute edge of a data write.
        @(negedge clk);
        memory_type_data = 1'b1; write = 1'b1; addr = 8'h02; data_in = 8'h77; select = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        select = 1'b0;
        @(posedge clk);
        @(negedge clk);
        release_and_wait(n);
        check("rst_mid_data_init", 32'(n), 32'd32);
        access("code_rd10", 1'b0, 1'b0, 8'h10, 8'h00, 8'hFF, 1'b0);
        access("data_rd02", 1'b1, 1'b0, 8'h02, 8'h00, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
